// File: rtl/load_ext_align_if.sv
// Request/response bundle between data-memory read and the load aligner.
// The master issues requests and drives out_ready; the slave is the aligner.
interface load_ext_align_if #(
  parameter int WORD_W = 32
);
  localparam int OFF_W = $clog2(WORD_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [OFF_W-1:0]  in_off;
  logic [1:0]        in_size;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_misalign;

  modport master (
    output in_valid, in_data, in_off, in_size, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_misalign
  );

  modport slave (
    input  in_valid, in_data, in_off, in_size, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_misalign
  );
endinterface

// File: rtl/load_ext_align.sv
// Two-stage load aligner: S1 selects the addressed lane and flags misalignment,
// S2 extends to WORD_W (or places an upper immediate) and holds the result.
module load_ext_align #(
  parameter int WORD_W = 32,
  parameter int OFF_W  = $clog2(WORD_W / 8),
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  load_ext_align_if.slave  bus,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_UPPER = 2'b11;

  // Stage 1 state
  logic              r_s1_valid;
  logic [WORD_W-1:0] r_s1_raw;
  logic [1:0]        r_s1_size;
  logic              r_s1_signed;
  logic              r_s1_mis;

  // Stage 2 state (drives the outputs directly)
  logic              r_s2_valid;
  logic [WORD_W-1:0] r_out_data;
  logic              r_out_mis;
  logic [CNT_W-1:0]  r_err_count;

  logic              w_s2_ready;
  logic              w_s1_ready;
  logic              w_accept;
  logic [OFF_W+2:0]  w_shift;
  logic [WORD_W-1:0] w_lane;
  logic [WORD_W-1:0] w_raw;
  logic              w_mis;
  logic              w_fill8;
  logic              w_fill16;
  logic [WORD_W-1:0] w_ext;
  logic [WORD_W-1:0] w_s2_data;

  assign w_s2_ready = !r_s2_valid || bus.out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign w_accept   = bus.in_valid && w_s1_ready;
  assign w_shift    = {bus.in_off, 3'b000};
  assign w_lane     = bus.in_data >> w_shift;

  // Lane selection and misalignment classification of the incoming request.
  always_comb begin
    w_raw = {WORD_W{1'b0}};
    w_mis = 1'b0;
    case (bus.in_size)
      SZ_BYTE: begin
        w_raw = w_lane;
        w_mis = 1'b0;
      end
      SZ_HALF: begin
        w_raw = w_lane;
        w_mis = bus.in_off[0];
      end
      SZ_WORD: begin
        w_raw = bus.in_data;
        w_mis = (bus.in_off != {OFF_W{1'b0}});
      end
      SZ_UPPER: begin
        w_raw = {{(WORD_W-16){1'b0}}, bus.in_data[15:0]};
        w_mis = 1'b0;
      end
      default: begin
        w_raw = {WORD_W{1'b0}};
        w_mis = 1'b0;
      end
    endcase
  end

  assign w_fill8  = r_s1_signed & r_s1_raw[7];
  assign w_fill16 = r_s1_signed & r_s1_raw[15];

  // Extension / upper placement of the S1 value; misaligned results read as zero.
  always_comb begin
    w_ext = {WORD_W{1'b0}};
    case (r_s1_size)
      SZ_BYTE:  w_ext = {{(WORD_W-8){w_fill8}}, r_s1_raw[7:0]};
      SZ_HALF:  w_ext = {{(WORD_W-16){w_fill16}}, r_s1_raw[15:0]};
      SZ_WORD:  w_ext = r_s1_raw;
      SZ_UPPER: w_ext = {r_s1_raw[15:0], {(WORD_W-16){1'b0}}};
      default:  w_ext = {WORD_W{1'b0}};
    endcase
    if (r_s1_mis) begin
      w_s2_data = {WORD_W{1'b0}};
    end else begin
      w_s2_data = w_ext;
    end
  end

  // Stage 1 register: captures on accept, empties when S2 takes its contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_raw    <= {WORD_W{1'b0}};
      r_s1_size   <= 2'b00;
      r_s1_signed <= 1'b0;
      r_s1_mis    <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid  <= 1'b1;
      r_s1_raw    <= w_raw;
      r_s1_size   <= bus.in_size;
      r_s1_signed <= bus.in_signed;
      r_s1_mis    <= w_mis;
    end else if (w_s2_ready) begin
      r_s1_valid  <= 1'b0;
    end
  end

  // Stage 2 register: output holds stable while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_out_data <= {WORD_W{1'b0}};
      r_out_mis  <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_s2_data;
        r_out_mis  <= r_s1_mis;
      end
    end
  end

  // Saturating misalignment counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= {CNT_W{1'b0}};
    end else if (err_clr) begin
      r_err_count <= {CNT_W{1'b0}};
    end else if (w_accept && w_mis && (r_err_count != {CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready     = w_s1_ready;
  assign bus.out_valid    = r_s2_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_misalign = r_out_mis;
  assign err_count        = r_err_count;

endmodule

// File: tb/tb_load_ext_align.sv
// Self-checking bench for load_ext_align: directed scenarios plus a randomized
// stream scored against an arithmetic reference model.
module tb_load_ext_align;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       err_clr;
  logic [7:0] err_count;
  int         n_tests = 0;
  int         n_fail  = 0;

  load_ext_align_if #(.WORD_W(W)) bus ();

  load_ext_align #(.WORD_W(W), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Returns {misaligned, expected out_data} using plain integer arithmetic.
  function automatic logic [32:0] ref_model(input logic [31:0] d, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    logic [31:0] lane;
    logic        mis;
    lane = d >> (8 * int'(off));
    v    = 32'd0;
    mis  = 1'b0;
    case (sz)
      2'd0: begin
        v = lane % 32'd256;
        if (sg && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        mis = (int'(off) % 2) == 1;
        v = lane % 32'd65536;
        if (sg && v >= 32'd32768) v = v - 32'd65536;
      end
      2'd2: begin
        mis = (off != 2'd0);
        v = d;
      end
      default: v = (d % 32'd65536) * 32'd65536;
    endcase
    if (mis) v = 32'd0;
    return {mis, v};
  endfunction

  task automatic flush();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    err_clr       = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] off,
                      input logic [1:0] sz, input logic sg);
    int k;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_off    = off;
    bus.in_size   = sz;
    bus.in_signed = sg;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_accept: in_ready=%0b, required 1 within 20 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    err_clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_data = 32'd0; bus.in_off = 2'd0; bus.in_size = 2'd0; bus.in_signed = 1'b0;
    #12;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_misalign !== 1'b0 ||
        err_count !== 8'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h mis=%b cnt=%0d rdy=%b, required 0 0 0 0 1",
               bus.out_valid, bus.out_data, bus.out_misalign, err_count, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] d_t [5] = '{32'h12803456, 32'h12803456, 32'h80017FFF, 32'h80017FFF, 32'h0000ABCD};
    logic [1:0]  o_t [5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [1:0]  s_t [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11};
    logic        g_t [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] e_t [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00007FFF, 32'hABCD0000};
    flush();
    for (int i = 0; i < 5; i++) begin
      send(d_t[i], o_t[i], s_t[i], g_t[i]);
      n_tests++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_early_%0d: out_valid=%b one edge after accept, required 0", i, bus.out_valid);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e_t[i] || bus.out_misalign !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_%0d: valid=%b data=%h mis=%b, required 1 %h 0",
                 i, bus.out_valid, bus.out_data, bus.out_misalign, e_t[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  o_t [3] = '{2'd1, 2'd3, 2'd2};
    logic [1:0]  s_t [3] = '{2'b10, 2'b01, 2'b01};
    logic [7:0]  c_t [3] = '{8'd1, 8'd2, 8'd2};
    logic        m_t [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] e_t [3] = '{32'h0, 32'h0, 32'h0000CAFE};
    flush();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(32'hCAFEBABE, o_t[i], s_t[i], 1'b0);
      n_tests++;
      if (err_count !== c_t[i]) begin
        n_fail++;
        $display("FAIL misalign_count_%0d: err_count=%0d, required %0d", i, err_count, c_t[i]);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_misalign !== m_t[i] || bus.out_data !== e_t[i]) begin
        n_fail++;
        $display("FAIL misalign_out_%0d: valid=%b mis=%b data=%h, required 1 %b %h",
                 i, bus.out_valid, bus.out_misalign, bus.out_data, m_t[i], e_t[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [31:0] got [$];
    int cyc [$];
    int acc;
    logic hs;
    flush();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_off = 2'd0; bus.in_size = 2'b10; bus.in_signed = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      bus.in_valid = (acc < 4);
      bus.in_data  = words[acc % 4];
      #1;
      hs = bus.in_valid && bus.in_ready;
      if (c >= 2) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11111111) begin
          n_fail++;
          $display("FAIL stall_hold_c%0d: valid=%b data=%h, required 1 11111111", c, bus.out_valid, bus.out_data);
        end
      end
      @(posedge clk);
      if (hs) acc++;
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (acc != 2 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_fill: accepted=%0d in_ready=%b, required 2 0", acc, bus.in_ready);
    end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (acc < 4);
      bus.in_data   = words[acc % 4];
      #1;
      hs = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_data);
        cyc.push_back(c);
      end
      @(posedge clk);
      if (hs) acc++;
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL drain_count: emitted=%0d, required 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (got[i] !== words[i]) begin
          n_fail++;
          $display("FAIL drain_order_%0d: data=%h, required %h", i, got[i], words[i]);
        end
      end
      n_tests++;
      if (cyc[3] - cyc[0] != 3) begin
        n_fail++;
        $display("FAIL drain_rate: span=%0d cycles, required 3", cyc[3] - cyc[0]);
      end
    end
  endtask

  task automatic test_counter_sat();
    int acc;
    logic hs;
    flush();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    acc = 0;
    for (int c = 0; c < 600 && acc < 260; c++) begin
      if (c > 0) @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 32'h55AA55AA;
      bus.in_off = 2'd1; bus.in_size = 2'b10; bus.in_signed = 1'b0;
      #1;
      hs = bus.in_ready;
      @(posedge clk);
      if (hs) acc++;
    end
    #1;
    bus.in_valid = 1'b0;
    n_tests++;
    if (acc != 260 || err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL counter_saturate: accepted=%0d err_count=%0d, required 260 255", acc, err_count);
    end
  endtask

  task automatic test_clr_priority();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 32'h01020304;
    bus.in_off = 2'd3; bus.in_size = 2'b10; bus.in_signed = 1'b0;
    err_clr = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_accept: in_ready=%b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    err_clr = 1'b0;
    n_tests++;
    if (err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_priority: err_count=%0d, required 0", err_count);
    end
    send(32'h01020304, 2'd1, 2'b01, 1'b0);
    n_tests++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL clr_then_inc: err_count=%0d, required 1", err_count);
    end
  endtask

  task automatic test_reset_mid();
    flush();
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(32'hAAAA0001, 2'd0, 2'b10, 1'b0);
    send(32'hBBBB0002, 2'd0, 2'b10, 1'b0);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_full: valid=%b in_ready=%b, required 1 0", bus.out_valid, bus.in_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.in_ready !== 1'b1 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_immediate: valid=%b data=%h rdy=%b cnt=%0d, required 0 0 1 0",
               bus.out_valid, bus.out_data, bus.in_ready, err_count);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    send(32'h0000F0F0, 2'd1, 2'b00, 1'b1);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_stale: out_valid=%b one edge after accept, required 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFFFFF0) begin
      n_fail++;
      $display("FAIL midreset_latency: valid=%b data=%h, required 1 fffffff0", bus.out_valid, bus.out_data);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ghost: out_valid=%b after single request, required 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    logic [32:0] exp;
    logic [7:0]  m_cnt;
    logic        in_hs;
    flush();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_cnt = 8'd0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      if (!bus.in_valid) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.in_data   = $urandom;
        bus.in_off    = 2'($urandom_range(0, 3));
        bus.in_size   = 2'($urandom_range(0, 3));
        bus.in_signed = 1'($urandom_range(0, 1));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if (err_count !== m_cnt) begin
        n_fail++;
        $display("FAIL rand_count_c%0d: err_count=%0d, required %0d", c, err_count, m_cnt);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious_c%0d: out data=%h with nothing outstanding", c, bus.out_data);
        end else begin
          exp = q.pop_front();
          if ({bus.out_misalign, bus.out_data} !== exp) begin
            n_fail++;
            $display("FAIL rand_data_c%0d: mis=%b data=%h, required %b %h",
                     c, bus.out_misalign, bus.out_data, exp[32], exp[31:0]);
          end
        end
      end
      in_hs = bus.in_valid && bus.in_ready;
      if (in_hs) begin
        exp = ref_model(bus.in_data, bus.in_off, bus.in_size, bus.in_signed);
        q.push_back(exp);
        if (exp[32] && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
      @(posedge clk);
      #1;
      if (in_hs) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL drain_spurious: data=%h with nothing outstanding", bus.out_data);
        end else begin
          exp = q.pop_front();
          if ({bus.out_misalign, bus.out_data} !== exp) begin
            n_fail++;
            $display("FAIL drain_data: mis=%b data=%h, required %b %h",
                     bus.out_misalign, bus.out_data, exp[32], exp[31:0]);
          end
        end
      end
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_lost: %0d results never emitted, required 0", q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_misalign();
    test_backpressure();
    test_counter_sat();
    test_clr_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_ext_align.md
# load_ext_align

Parametrised load-data aligner and sign/zero extender for the MIPS load/store datapath, the successor to the fixed 16-to-32 sign extender. Selects a byte, halfword or word lane from a memory read word by byte offset, extends it signed or unsigned to `WORD_W`, and also provides an upper-immediate (LUI-style) placement mode. It is a two-stage valid/ready pipeline between data-memory read and register write-back. It flags misaligned accesses and keeps a saturating misalignment event counter.

## Interface
- `WORD_W`, 32, datapath width in bits; multiple of 16, power of two, ≥ 32.
- `OFF_W`, $clog2(WORD_W/8), byte-offset width (derived, do not override).
- `CNT_W`, 8, width of the misalignment counter.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  request accepted when `in_valid && in_ready`.
- `in_data`  input  WORD_W  memory read word, or immediate in low 16 bits for upper mode.
- `in_off`  input  OFF_W  byte offset of access, little-endian (lane k = bits 8k+7:8k).
- `in_size`  input  2  00 byte, 01 half, 10 word, 11 upper.
- `in_signed`  input  1  1 = sign-extend, 0 = zero-extend; ignored for word/upper.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts when `out_valid && out_ready`.
- `out_data`  output  WORD_W  aligned, extended result.
- `out_misalign`  output  1  result belongs to a misaligned request.
- `err_clr`  input  1  synchronous clear of `err_count`.
- `err_count`  output  CNT_W  saturating count of accepted misaligned requests.

## Operation
- Stage 1 (S1): on accept, register the lane-shifted raw value, size, signed flag and misalign flag.
  - Byte: raw = `in_data >> (8*in_off)`.
  - Half: raw = `in_data >> (8*in_off)`.
  - Word: raw = `in_data`.
  - Upper: raw = `in_data[15:0]`.
- Misalignment rules:
  - Half is misaligned if `in_off[0]=1`.
  - Word is misaligned if `in_off != 0`.
  - Byte and upper are never misaligned.
- Stage 2 (S2): form `out_data` from the S1 values.
  - Byte: low 8 bits, extended.
  - Half: low 16 bits, extended.
  - Word: passthrough.
  - Upper: `{raw[15:0], {WORD_W-16{1'b0}}}`.
  - Extension fills with bit 7 (byte) or bit 15 (half) when signed, else with zeros.
- A misaligned request still flows through the pipeline, with `out_data` forced to 0 and `out_misalign=1`.
- Flow control is a standard pipeline; no request is ever dropped or duplicated.
  - `s2_ready = !s2_valid || out_ready`.
  - `s1_ready = !s1_valid || s2_ready`.
  - `in_ready = s1_ready`, which is combinational from `out_ready`.
- `err_count` increments by 1 on each accepted misaligned request and saturates at 2^CNT_W−1.
  - `err_clr` has priority: if clear and increment occur in the same cycle, the result is 0.

## Timing
- Reset, asynchronous, effective immediately:
  - `out_valid=0`, `out_data=0`, `out_misalign=0`, `err_count=0`.
  - Both stage valids clear, so `in_ready=1` while reset is asserted and after release.
- Latency: a request accepted at edge N appears on `out_valid`/`out_data` after edge N+1, provided S2 is free.
- Throughput: one request per cycle while `out_ready=1`.
- Stall: when `out_valid && !out_ready`, `out_data`, `out_misalign` and `out_valid` hold stable.
  - S1 fills.
  - `in_ready` falls once S1 is also full.
  - Two requests are held at most.
- Release: when `out_ready` rises with both stages full, S2 takes S1 and S1 accepts new input in the same edge.
- Reset mid-operation: in-flight requests are discarded; no partial output.
- `err_count` updates at the acceptance edge, not at the output.

## Test plan
- Byte signed: `in_data=0x12_80_34_56`, off=2, size=00, signed=1 -> `out_data=0xFFFFFF80` two edges after accept; with signed=0 -> `0x00000080`.
- Half and upper:
  - `in_data=0x8001_7FFF`, off=2, size=01, signed=1 -> `0xFFFF8001`.
  - off=0 -> `0x00007FFF`.
  - size=11 with `in_data=0x0000_ABCD` -> `0xABCD0000`.
- Misalignment:
  - Word at off=1 -> `out_data=0`, `out_misalign=1`, `err_count` 0->1.
  - Half at off=3 -> `err_count=2`.
  - Half at off=2 -> no increment.
- Backpressure: stream 4 words 0x11111111..0x44444444 with `out_ready=0` -> `in_ready` drops after 2 accepts and `out_data` holds 0x11111111; then `out_ready=1` -> all 4 emitted in order, one per cycle, none lost.
- Counter edge:
  - 260 misaligned requests -> `err_count=255`.
  - `err_clr` asserted in the same cycle as a misaligned accept -> 0.
- Reset mid-stream: assert `reset` with both stages full -> `out_valid=0`, `out_data=0` immediately, `in_ready=1`; after release, the first new request emerges with 2-cycle latency.
